// File: rtl/cdb_arbiter_pkg.sv
// Shared system definitions used by the CDB arbiter and its result buffers.
// ROB_SIZE and XLEN are provided here as overridable macros.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    localparam int unsigned NUM_FU_DEFAULT = 3;
    localparam int unsigned ROB_TAG_W      = $clog2(`ROB_SIZE);

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2
    } FUNC_UNIT;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] Tag;
        logic [`XLEN-1:0]     Value;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-functional-unit result buffer: a DEPTH-entry FIFO with wrapping
// pointers. Squash empties it synchronously and overrides push/pop.
module cdb_result_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = logic [31:0]
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   squash,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t data_i,
    output entry_t data_o,
    output logic   empty_o,
    output logic   ready_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push_i && (cnt_q != CNT_W'(DEPTH)) && !squash;
    assign do_pop  = pop_i  && (cnt_q != '0)            && !squash;

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign ready_o = (cnt_q != CNT_W'(DEPTH));

    // Next pointer/count: squash clears, otherwise advance on push/pop.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (squash) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless while count is 0.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_FU functional units,
// grants one per cycle round-robin and drives a registered CDB packet.
// Optional macro CDB_BYPASS_EN lets an input arriving at an empty buffer
// compete in the same cycle and broadcast without being buffered.
module cdb_arbiter
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU = NUM_FU_DEFAULT,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = $clog2(`ROB_SIZE)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU-1:0][`XLEN-1:0]   fu_value,
    output logic [NUM_FU-1:0]              fu_ready,
    output CDB_PACKET                      cdb_packet
);

    localparam int unsigned RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [`XLEN-1:0] value;
    } entry_t;

    entry_t            in_entry   [NUM_FU];
    entry_t            fifo_head  [NUM_FU];
    logic [NUM_FU-1:0] fifo_empty;
    logic [NUM_FU-1:0] fifo_ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] cand;

    logic              grant_valid;
    logic [RR_W-1:0]   grant_idx;
    entry_t            sel_entry;

    logic [RR_W-1:0]   rr_q, rr_d;
    CDB_PACKET         cdb_q, cdb_d;

    assign fu_ready   = fifo_ready;
    assign cdb_packet = cdb_q;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_port
        logic granted;
        assign granted     = grant_valid && (grant_idx == RR_W'(g));
        assign in_entry[g] = '{tag: fu_tag[g], value: fu_value[g]};
`ifdef CDB_BYPASS_EN
        // An input at an empty buffer competes directly; if it wins it is
        // broadcast straight from the port and never written to the buffer.
        assign cand[g] = !fifo_empty[g] || fu_valid[g];
        assign push[g] = fu_valid[g] && fifo_ready[g] && !(granted && fifo_empty[g]);
`else
        assign cand[g] = !fifo_empty[g];
        assign push[g] = fu_valid[g] && fifo_ready[g];
`endif
        assign pop[g]  = granted && !fifo_empty[g];

        cdb_result_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .squash  (squash),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .data_i  (in_entry[g]),
            .data_o  (fifo_head[g]),
            .empty_o (fifo_empty[g]),
            .ready_o (fifo_ready[g])
        );
    end

    // Round-robin search from rr_q upward with wrap; first candidate wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            idx = (32'(rr_q) + off) % NUM_FU;
            if (!grant_valid && cand[RR_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = RR_W'(idx);
            end
        end
    end

    // Winning entry: buffer head, or the live input when bypassing.
    always_comb begin
        sel_entry = fifo_head[grant_idx];
`ifdef CDB_BYPASS_EN
        if (fifo_empty[grant_idx]) sel_entry = in_entry[grant_idx];
`endif
    end

    // Next broadcast and round-robin pointer; squash overrides any grant.
    always_comb begin
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        rr_d        = rr_q;
        if (squash) begin
            rr_d = '0;
        end else if (grant_valid) begin
            cdb_d.valid = 1'b1;
            cdb_d.Tag   = ROB_TAG_W'(sel_entry.tag);
            cdb_d.Value = sel_entry.value;
            rr_d        = (grant_idx == RR_W'(NUM_FU - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    // Output packet and round-robin pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_q <= '0;
            rr_q  <= '0;
        end else begin
            cdb_q <= cdb_d;
            rr_q  <= rr_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, no bypass).
module tb_cdb_arbiter;
    import sys_defs::*;

    localparam int unsigned NUM_FU = 3;
    localparam int unsigned TAG_W  = ROB_TAG_W;
    localparam int unsigned XW     = `XLEN;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         squash;
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
    logic [NUM_FU-1:0][XW-1:0]    fu_value;
    logic [NUM_FU-1:0]            fu_ready;
    CDB_PACKET                    cdb_packet;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .DEPTH  (2),
        .TAG_W  (TAG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .fu_value   (fu_value),
        .fu_ready   (fu_ready),
        .cdb_packet (cdb_packet)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pkt(input logic v, input int t, input logic [XW-1:0] val);
        logic [TAG_W-1:0] tt;
        tt = TAG_W'(t);
        return 64'({v, tt, val});
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fu_valid = '0;
        squash   = 1'b0;
    endtask

    task automatic drive(input int p, input int tag, input logic [XW-1:0] val);
        fu_valid[p] = 1'b1;
        fu_tag[p]   = TAG_W'(tag);
        fu_value[p] = val;
    endtask

    task automatic do_squash();
        squash = 1'b1;
        tick();
        squash = 1'b0;
    endtask

    initial begin
        int          base   [3];
        int          n_send [3];
        int          q_idx  [3];
        int          rx_idx [3];
        logic [2:0]  rdy;
        logic [2:0]  vld;
        int          p2_acc;
        int          p;
        int          t;

        reset    = 1'b0;
        fu_tag   = '0;
        fu_value = '0;
        idle();
        #2;
        check("rst_pkt", 64'(cdb_packet), 64'd0);
        check("rst_ready", 64'(fu_ready), 64'd7);
        tick();
        tick();
        reset = 1'b1;

        // Single result: two-edge latency, then valid drops with tag/value held.
        drive(0, 5, 32'h1234);
        tick();
        idle();
        check("single_e1", 64'(cdb_packet.valid), 64'd0);
        tick();
        check("single_e2", 64'(cdb_packet), pkt(1'b1, 5, 32'h1234));
        tick();
        check("single_hold", 64'(cdb_packet), pkt(1'b0, 5, 32'h1234));

        do_squash();
        check("squash_rr0", 64'(dut.rr_q), 64'd0);

        // Contention from rr_ptr 0.
        drive(0, 1, 32'h111);
        drive(1, 2, 32'h222);
        drive(2, 3, 32'h333);
        tick();
        idle();
        tick();
        check("cont_1", 64'(cdb_packet), pkt(1'b1, 1, 32'h111));
        tick();
        check("cont_2", 64'(cdb_packet), pkt(1'b1, 2, 32'h222));
        tick();
        check("cont_3", 64'(cdb_packet), pkt(1'b1, 3, 32'h333));
        tick();
        check("cont_idle", 64'(cdb_packet), pkt(1'b0, 3, 32'h333));
        check("cont_rr", 64'(dut.rr_q), 64'd0);

        // Fairness: port 0 streaming, port 2 once.
        drive(0, 10, 32'hF000_000A);
        drive(2, 20, 32'hF000_0014);
        tick();
        fu_valid[2] = 1'b0;
        drive(0, 11, 32'hF000_000B);
        tick();
        check("fair_e2", 64'(cdb_packet), pkt(1'b1, 10, 32'hF000_000A));
        drive(0, 12, 32'hF000_000C);
        tick();
        check("fair_e3_port2", 64'(cdb_packet), pkt(1'b1, 20, 32'hF000_0014));
        idle();
        tick();
        check("fair_e4", 64'(cdb_packet), pkt(1'b1, 11, 32'hF000_000B));
        tick();
        check("fair_e5", 64'(cdb_packet), pkt(1'b1, 12, 32'hF000_000C));
        tick();
        check("fair_idle", 64'(cdb_packet.valid), 64'd0);

        // Backpressure: ports 0/1 keep the bus busy, port 2 pushes three.
        do_squash();
        base   = '{1, 9, 20};
        n_send = '{6, 6, 3};
        q_idx  = '{0, 0, 0};
        rx_idx = '{0, 0, 0};
        p2_acc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (q_idx[i] < n_send[i])
                    drive(i, base[i] + q_idx[i], 32'hA500_0000 | 32'(base[i] + q_idx[i]));
                else
                    fu_valid[i] = 1'b0;
            end
            rdy = fu_ready;
            vld = fu_valid;
            tick();
            for (int i = 0; i < 3; i++)
                if (rdy[i] && vld[i]) q_idx[i]++;
            if (rdy[2] && vld[2]) begin
                p2_acc++;
                if (p2_acc == 2) check("bp_full", 64'(fu_ready[2]), 64'd0);
            end
            if (cyc == 3) check("bp_e4_port2", 64'(cdb_packet), pkt(1'b1, 20, 32'hA500_0014));
            if (cdb_packet.valid) begin
                t = int'(cdb_packet.Tag);
                p = (t >= 20) ? 2 : (t >= 9) ? 1 : 0;
                check("bp_order", 64'(t), 64'(base[p] + rx_idx[p]));
                check("bp_value", 64'(cdb_packet.Value), 64'(32'hA500_0000 | 32'(t)));
                rx_idx[p]++;
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            check("bp_sent", 64'(q_idx[i]), 64'(n_send[i]));
            check("bp_recv", 64'(rx_idx[i]), 64'(n_send[i]));
        end

        // Tag 0 passes through unmodified.
        do_squash();
        drive(1, 0, 32'hFFFF_FFFF);
        tick();
        idle();
        tick();
        check("tag0", 64'(cdb_packet), pkt(1'b1, 0, 32'hFFFF_FFFF));
        tick();

        // Squash with two buffered results and a new input in flight.
        drive(0, 3, 32'h33);
        drive(1, 4, 32'h44);
        tick();
        idle();
        drive(2, 7, 32'h77);
        squash = 1'b1;
        tick();
        idle();
        check("sq_valid", 64'(cdb_packet.valid), 64'd0);
        check("sq_ready", 64'(fu_ready), 64'd7);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sq_quiet", 64'(cdb_packet.valid), 64'd0);
        end

        // Asynchronous reset between edges with buffers occupied.
        drive(0, 5, 32'h55);
        drive(1, 6, 32'h66);
        drive(2, 7, 32'h77);
        tick();
        idle();
        tick();
        check("ar_pre", 64'(cdb_packet), pkt(1'b1, 5, 32'h55));
        #3;
        reset = 1'b0;
        #1;
        check("ar_pkt", 64'(cdb_packet), 64'd0);
        check("ar_ready", 64'(fu_ready), 64'd7);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ar_quiet", 64'(cdb_packet.valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 3: number of functional-unit result ports (index 0 ALU, 1 MULT, 2 MEM).
REQ-002 Parameter DEPTH, default 2: result-buffer entries per functional unit.
REQ-003 Parameter TAG_W, default $clog2(`ROB_SIZE): ROB tag width.
REQ-004 Ports: clock  in  1  single clock; all state changes on its rising edge.
REQ-005 Ports: reset  in  1  reset, asynchronous and active-low (asserted at 0).
REQ-006 Ports: squash  in  1  synchronous flush from ROB on mispredict.
REQ-007 Ports: fu_valid  in  NUM_FU  result present on port i.
REQ-008 Ports: fu_tag  in  NUM_FU x TAG_W  ROB tag of the result.
REQ-009 Ports: fu_value  in  NUM_FU x `XLEN  result value.
REQ-010 Ports: fu_ready  out  NUM_FU  port i can accept a result this cycle.
REQ-011 Ports: cdb_packet  out  CDB_PACKET {valid, Tag, Value}  registered broadcast to RS and ROB.

Function
REQ-012 Port i SHALL enqueue a result on a clock edge where fu_valid[i] and fu_ready[i] are both 1.
REQ-013 fu_ready[i] SHALL equal (count[i] != DEPTH), decoded from registered state only, with no combinational path from fu_valid or the grant.
REQ-014 When fu_valid[i]=1 and fu_ready[i]=0, the result SHALL be ignored; the producer holds it.
REQ-015 Each buffer SHALL be FIFO with read/write pointers wrapping modulo DEPTH; same-cycle enqueue and dequeue SHALL leave count unchanged.
REQ-016 Each cycle at most one non-empty buffer SHALL be granted; its head SHALL be dequeued and written to cdb_packet at that edge.
REQ-017 Round-robin arbitration: search starts at rr_ptr and proceeds in ascending index with wrap.
REQ-018 After a grant to k, rr_ptr SHALL become (k+1) mod NUM_FU; with no grant, rr_ptr SHALL be unchanged.
REQ-019 With no grant, cdb_packet.valid SHALL be 0 on the next cycle; Tag and Value SHALL hold their previous values.
REQ-020 Base latency: a result accepted at edge N SHALL be broadcast no earlier than edge N+1, visible after N+1.
REQ-021 Tag and Value SHALL pass through unmodified, including tag 0.
REQ-022 squash=1 at an edge SHALL empty all buffers, clear cdb_packet.valid and reset rr_ptr to 0; same-cycle enqueues and grants SHALL be discarded.
REQ-023 squash has priority over enqueue, dequeue and bypass.

Reset
REQ-024 While reset=0, asynchronously: all counts and pointers 0, rr_ptr 0, cdb_packet all-zero, fu_ready all 1 (given DEPTH>=1).
REQ-025 Reset asserted mid-operation SHALL drop all buffered results; the first edge after release behaves as from empty.

Configuration
REQ-026 Macro CDB_BYPASS_EN, when defined: an input on a port whose buffer is empty SHALL join the same-cycle arbitration as that port's head. If granted, it is broadcast at the accepting edge without being buffered (latency 1 edge); otherwise it is enqueued.
REQ-027 Without CDB_BYPASS_EN: no bypass path; every result is buffered first, and the minimum accept-to-broadcast latency is 2 edges.

Structure
REQ-028 CDB_PACKET, FUNC_UNIT and the NUM_FU default SHALL live in the shared sys_defs package; ROB_SIZE and XLEN macros come from there.
REQ-029 Per-port buffering SHALL be one sub-module, cdb_result_fifo (parameters DEPTH, entry type), instantiated NUM_FU times; arbitration and the output register stay in cdb_arbiter.

Verification
REQ-030 Single result: fu_valid[0]=1, tag=5, value=0x1234 for one cycle -> cdb_packet {1,5,0x1234} after edge 2 (edge 1 with CDB_BYPASS_EN), then valid=0.
REQ-031 Contention: all three ports valid in the same cycle, tags 1/2/3, rr_ptr=0 -> broadcasts tag 1, 2, 3 on consecutive cycles, then rr_ptr=0.
REQ-032 Fairness: port 0 continuously valid and port 2 valid once -> port 2 is granted within NUM_FU cycles of entering its buffer.
REQ-033 Full/backpressure: CDB kept busy by ports 0 and 1, three pushes to port 2 -> fu_ready[2]=0 after 2 accepts; the third value is held and accepted later, with no loss or duplication.
REQ-034 Squash: two results buffered plus a new input while squash=1 -> the next cycle has valid=0, all fu_ready=1, and nothing is broadcast afterwards.
REQ-035 Async reset: reset driven 0 between edges with buffers non-empty -> outputs zero immediately, before the next edge; no stale broadcast after release.
